// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic pipeline stage: stage state encoding and
// the packed payload structs that inter-stage registers carry.
package pipe_stage_elastic_pkg;

    // Encoding doubles as the occupancy count (0, 1 or 2 held entries).
    typedef enum logic [1:0] {
        STAGE_EMPTY = 2'd0,
        STAGE_ONE   = 2'd1,
        STAGE_TWO   = 2'd2
    } lc3b_stage_state;

    // Number of entries a stage can hold (main + skid).
    localparam int unsigned StageDepth = 2;

    // IF/ID payload: fetched instruction and its address.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
    } lc3b_if_id_payload;

    // ID/EX payload: decoded control word plus operands.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] sr1_val;
        logic [15:0] sr2_val;
        logic [15:0] imm;
        logic [2:0]  dr;
        logic [3:0]  alu_op;
        logic        ld_reg;
        logic        ld_cc;
        logic        mem_rd;
        logic        mem_wr;
    } lc3b_id_ex_payload;

    // EX/MEM payload: ALU result and memory request.
    typedef struct packed {
        logic [15:0] alu_out;
        logic [15:0] st_data;
        logic [2:0]  dr;
        logic        ld_reg;
        logic        ld_cc;
        logic        mem_rd;
        logic        mem_wr;
    } lc3b_ex_mem_payload;

    // MEM/WB payload: write-back value and destination.
    typedef struct packed {
        logic [15:0] wb_val;
        logic [2:0]  dr;
        logic        ld_reg;
        logic        ld_cc;
    } lc3b_mem_wb_payload;

    localparam int unsigned IfIdPayloadW  = $bits(lc3b_if_id_payload);
    localparam int unsigned IdExPayloadW  = $bits(lc3b_id_ex_payload);
    localparam int unsigned ExMemPayloadW = $bits(lc3b_ex_mem_payload);
    localparam int unsigned MemWbPayloadW = $bits(lc3b_mem_wb_payload);

    // Occupancy count for a given state.
    function automatic logic [1:0] stage_occupancy(lc3b_stage_state s);
        return logic'(s == STAGE_ONE) ? 2'd1 : (s == STAGE_TWO) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One payload register of the elastic stage: load-enabled, async
// active-low reset to RESET_VALUE.
module pipe_stage_slot #(
    parameter int unsigned       WIDTH       = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Capture d_i when load_i is asserted, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VALUE;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic WIDTH-bit pipeline stage with valid/ready handshakes, a 2-entry
// skid buffer, synchronous flush and a legacy stall input. in_ready is
// registered so the stall path back through the pipeline is cut here.
// Optional performance counters: define PIPE_STAGE_PERF_EN.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int unsigned       WIDTH       = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cycles,
`endif
    output logic [1:0]       occupancy
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_stage_elastic: WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_elastic: CNT_W must be at least 1");
    end

    lc3b_stage_state state_q, state_d;
    logic            in_ready_q, in_ready_d;

    logic             in_fire, out_fire;
    logic             main_load, skid_load;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != STAGE_EMPTY) & ~flush;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready & ~stall;
    assign out_data  = main_q;
    assign occupancy = stage_occupancy(state_q);

    // Next state and register load decisions; flush squashes everything.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_d = STAGE_EMPTY;
        end else begin
            unique case (state_q)
                STAGE_EMPTY: begin
                    if (in_fire) begin
                        state_d   = STAGE_ONE;
                        main_load = 1'b1;
                    end
                end
                STAGE_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d   = STAGE_TWO;
                        skid_load = 1'b1;
                    end else if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = STAGE_EMPTY;
                    end
                end
                STAGE_TWO: begin
                    // in_ready is low here, so only the drain case exists.
                    if (out_fire) begin
                        state_d   = STAGE_ONE;
                        main_load = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: state_d = STAGE_EMPTY;
            endcase
        end
        in_ready_d = (state_d != STAGE_TWO);
    end

    // State and registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STAGE_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_stage_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_stage_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, bubble_cycles_q;
    logic             stall_event, bubble_event;

    assign stall_event  = out_valid & ~(out_ready & ~stall);
    assign bubble_event = (state_q == STAGE_EMPTY);

    // Saturating counters; only reset clears them, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q  <= '0;
            bubble_cycles_q <= '0;
        end else begin
            if (stall_event && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (bubble_event && (bubble_cycles_q != {CNT_W{1'b1}})) begin
                bubble_cycles_q <= bubble_cycles_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed ID/EX-style stall register.
- A generic WIDTH-bit pipeline stage with a valid/ready handshake on both sides, a 2-entry skid buffer, synchronous flush (squash) and a legacy stall input.
- Sits between any two LC-3b pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Control words and data fields are packed into `in_data` by the instantiating stage.
- Sustains 1 transfer/cycle, and `in_ready` is fully registered, which breaks the combinational stall path back through the pipeline.

Parameters:
- WIDTH, 16, payload width in bits; must be at least 1.
- RESET_VALUE, '0, value held in both data registers after reset.
- CNT_W, 16, width of the performance counters; used only when PIPE_STAGE_PERF_EN is defined.

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload at the head of the stage.
- stall  in  1  legacy freeze; when 1, the effective `out_ready` is 0.
- flush  in  1  squash all held entries (branch mispredict / trap).
- occupancy  out  2  number of held entries: 0, 1 or 2.
- stall_cycles  out  CNT_W  present only with PIPE_STAGE_PERF_EN.
- bubble_cycles  out  CNT_W  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Definitions:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready & ~stall`.
- Reset (rst_n = 0, asynchronous):
  - State goes to EMPTY.
  - Main and skid registers are set to RESET_VALUE.
  - `in_ready = 1`, `out_valid = 0`, `occupancy = 0`, counters = 0.
  - Reset deassertion is synchronised by the existing reset bridge.
- States and transitions (EMPTY, ONE, TWO), evaluated at each clk edge when flush = 0:
  - EMPTY:
    - `in_fire` → ONE, main ← `in_data`.
    - Otherwise stay in EMPTY.
  - ONE:
    - `in_fire & ~out_fire` → TWO, skid ← `in_data`.
    - `in_fire & out_fire` → ONE, main ← `in_data`.
    - `~in_fire & out_fire` → EMPTY.
    - Otherwise hold.
  - TWO (`in_ready` = 0, so `in_fire` is impossible):
    - `out_fire` → ONE, main ← skid.
    - Otherwise hold.
- Outputs:
  - `in_ready` is a register: 1 in EMPTY and ONE, 0 in TWO.
  - `out_valid = (state != EMPTY) & ~flush`.
  - `out_data` = main register.
  - `occupancy` is the state encoding, 0/1/2.
- Latency:
  - `in_fire` at edge N gives `out_valid` from after edge N.
  - Back-to-back throughput is 1/cycle with `out_ready` held at 1.
- Ordering: FIFO. Payloads are never dropped, duplicated or reordered.
- Downstream stability: `out_valid` and `out_data` stay stable until `out_fire`. Only flush or reset may withdraw them.
- Upstream: may change or deassert `in_data`/`in_valid` in any cycle in which `in_fire` = 0.
- Flush:
  - Highest priority apart from reset.
  - In the flush cycle, `out_valid` = 0 combinationally, so no `out_fire` is possible.
  - Any `in_fire` in that cycle is discarded.
  - Next state is EMPTY and `in_ready` = 1.
  - Data registers are not cleared.
- Stall: identical to `out_ready` = 0, so the stage keeps accepting into the skid until TWO.
- Reset asserted mid-transfer: all entries are lost and the outputs take their reset values immediately.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - `stall_cycles` increments each cycle with `out_valid & ~(out_ready & ~stall)`.
  - `bubble_cycles` increments each cycle with state = EMPTY.
  - Both saturate at all-ones, clear on reset, and are not cleared by flush.
- Undefined: both ports and their logic are absent, with no other change.

Decomposition:
- Shared package (`lc3b_types`): add `lc3b_stage_state` enum {STAGE_EMPTY, STAGE_ONE, STAGE_TWO}, 2-bit encoding equal to occupancy.
- Packed typedefs for each stage's payload struct (e.g. `lc3b_id_ex_payload`) are also added to the package, so the payload width is `$bits` of that struct.
- One sub-module: `pipe_stage_slot`, a WIDTH-bit register with load enable and asynchronous active-low reset to RESET_VALUE, instantiated twice (main, skid).

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then release with in_valid = 0.
  - Expected: out_valid = 0, in_ready = 1, occupancy = 0, out_data = RESET_VALUE.
- Streaming:
  - Stimulus: push 0x0001..0x0010 with out_ready = 1 continuously.
  - Expected: out_data sequence 0x0001..0x0010, each 1 cycle after its in_fire, no gaps, occupancy never exceeds 1.
- Skid fill:
  - Stimulus: push 0xAAAA and 0xBBBB with stall = 1.
  - Expected: occupancy = 2, in_ready = 0, in_data 0xCCCC is not accepted.
  - Then release stall: outputs are 0xAAAA, 0xBBBB, 0xCCCC in order.
- Flush while full:
  - Stimulus: stage in TWO, assert flush together with in_valid = 1 (0x1234).
  - Expected: out_valid = 0 that cycle, occupancy = 0 next cycle, 0x1234 never appears.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst_n between clock edges while occupancy = 2.
  - Expected: out_valid = 0 and in_ready = 1 before the next edge.
- PERF build (PIPE_STAGE_PERF_EN, CNT_W = 4):
  - Stimulus: 20 cycles of out_valid = 1 with out_ready = 0.
  - Expected: stall_cycles saturates at 0xF.
